fminmax_pipe: RTL and testbench

- Two-stage pipelined FPU min/max unit for single-precision operands.
- Produces the ordering predicate x1 < x2 and uses it to select the smaller (FMIN) or larger (FMAX) operand.
- Sits beside the FPU comparator in the execute stage and uses the same ordering rules: signed-magnitude compare, with +0 and -0 treated as equal.
- Has a valid/ready handshake on both sides, so it can stall behind a busy writeback.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fp_order_pre.sv | 22 ++
 rtl/fminmax_pipe.sv | 92 +++++++++
 tb/tb_fminmax_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, min/max opcodes, operand field helpers
// and the stage-1 ordering precompute record.
package fpu_pkg;

   localparam int FP_W  = 32;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic OP_FMIN = 1'b0;
   localparam logic OP_FMAX = 1'b1;

   // Encoded as {s1, s2}
   typedef enum logic [1:0] {
      SC_PP = 2'b00,
      SC_PN = 2'b01,
      SC_NP = 2'b10,
      SC_NN = 2'b11
   } sign_cls_t;

   typedef struct packed {
      sign_cls_t cls;
      logic      mag_lt;
      logic      mag_eq;
      logic      both_zero;
   } ord_pre_t;

   function automatic logic fp_sign(input logic [FP_W-1:0] x);
      return x[FP_W-1];
   endfunction

   function automatic logic [FP_W-2:0] fp_mag(input logic [FP_W-1:0] x);
      return x[FP_W-2:0];
   endfunction

endpackage

// File: rtl/fp_order_pre.sv
// Stage-1 ordering precompute: sign class plus magnitude relations that the
// second stage folds into the final x1 < x2 flag.
module fp_order_pre
   import fpu_pkg::*;
(
   input  logic [FP_W-1:0] x1,
   input  logic [FP_W-1:0] x2,
   output ord_pre_t        pre
);

   logic [FP_W-2:0] m1, m2;

   always_comb begin
      m1            = fp_mag(x1);
      m2            = fp_mag(x2);
      pre.cls       = sign_cls_t'({fp_sign(x1), fp_sign(x2)});
      pre.mag_lt    = (m1 < m2);
      pre.mag_eq    = (m1 == m2);
      pre.both_zero = (m1 == '0) && (m2 == '0);
   end

endmodule

// File: rtl/fminmax_pipe.sv
// Two-stage FMIN/FMAX unit: S1 holds operands and ordering partials, S2 holds
// the resolved lt flag and selected operand. Valid/ready on both sides.
module fminmax_pipe
   import fpu_pkg::*;
#(
   parameter int W = FP_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] x2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         lt
);

   localparam int STAGES = 2;

   logic [STAGES:1] vld_pipe;
   logic            adv1, adv2;

   ord_pre_t        pre_c, s1_pre;
   logic [W-1:0]    s1_x1, s1_x2;
   logic            s1_op;
   logic            lt_c;
   logic [W-1:0]    y_c;

   fp_order_pre u_pre (
      .x1  (x1),
      .x2  (x2),
      .pre (pre_c)
   );

   assign adv2      = vld_pipe[1] & (~vld_pipe[2] | out_ready);
   assign adv1      = ~vld_pipe[1] | adv2;
   assign in_ready  = adv1;
   assign out_valid = vld_pipe[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         if (adv1)
            vld_pipe[1] <= in_valid;
         if (adv2)
            vld_pipe[2] <= 1'b1;
         else if (out_ready)
            vld_pipe[2] <= 1'b0;
      end
   end

   // Operand/partial registers carry no reset; their valid bit guards them.
   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         s1_x1  <= x1;
         s1_x2  <= x2;
         s1_op  <= op;
         s1_pre <= pre_c;
      end
   end

   always_comb begin
      lt_c = 1'b0;
      unique case (s1_pre.cls)
         SC_PP:   lt_c = s1_pre.mag_lt;
         SC_NP:   lt_c = ~s1_pre.both_zero;
         SC_PN:   lt_c = 1'b0;
         SC_NN:   lt_c = ~(s1_pre.mag_lt | s1_pre.mag_eq);
         default: lt_c = 1'b0;
      endcase
      // Ties fall to the else arm: FMIN returns x2, FMAX returns x1.
      if (s1_op == OP_FMAX)
         y_c = lt_c ? s1_x2 : s1_x1;
      else
         y_c = lt_c ? s1_x1 : s1_x2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y  <= '0;
         lt <= 1'b0;
      end else if (adv2) begin
         y  <= y_c;
         lt <= lt_c;
      end
   end

endmodule

// File: tb/tb_fminmax_pipe.sv
// Bench for fminmax_pipe: directed ordering/tie cases, backpressure, mid-flight
// reset and a randomized stream scored against a numeric ordering model.
module tb_fminmax_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        op;
   logic [31:0] x1, x2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y;
   logic        lt;

   int nvec = 0;
   int nerr = 0;

   fminmax_pipe #(.W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .x1        (x1),
      .x2        (x2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .lt        (lt)
   );

   always #5 clk = ~clk;

   // Signed-magnitude value as a plain integer: -0 and +0 both map to 0.
   function automatic longint key(input logic [31:0] a);
      longint m;
      m = longint'(a[30:0]);
      return a[31] ? -m : m;
   endfunction

   function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b);
      return key(a) < key(b);
   endfunction

   function automatic logic [31:0] ref_y(input logic o, input logic [31:0] a,
                                         input logic [31:0] b);
      if (o == 1'b0) return (key(a) < key(b)) ? a : b;   // smaller, tie -> b
      else           return (key(b) > key(a)) ? b : a;   // larger,  tie -> a
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0:       r = 32'h0000_0000;
         1:       r = 32'h8000_0000;
         2:       r = {1'b1, 31'($urandom_range(0, 15))};
         default: r = $urandom;
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; op = 1'b0; x1 = '0; x2 = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || y !== 32'h0 || lt !== 1'b0) begin
         nerr++;
         $display("FAIL reset_state: out_valid=%b y=%h lt=%b, want 0/0/0", out_valid, y, lt);
      end
      rst = 1'b0;
      step();
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   // One isolated pair: checks 2-cycle latency, result, and drain afterwards.
   task automatic run_pair(input string nm, input logic o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ey, input logic elt);
      in_valid = 1'b1; op = o; x1 = a; x2 = b; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      nvec++;
      if (out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL %s_early: out_valid=%b after 1 edge, want 0", nm, out_valid);
      end
      step();
      nvec++;
      if (out_valid !== 1'b1 || y !== ey || lt !== elt) begin
         nerr++;
         $display("FAIL %s: out_valid=%b y=%h lt=%b, want 1 y=%h lt=%b",
                  nm, out_valid, y, lt, ey, elt);
      end
      step();
      nvec++;
      if (out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL %s_drain: out_valid=%b, want 0", nm, out_valid);
      end
   endtask

   task automatic test_ordering();
      run_pair("fmin_pos",  1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b1);
      run_pair("fmax_mix",  1'b1, 32'hBF80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b1);
      run_pair("fmin_neg",  1'b0, 32'hC000_0000, 32'hBF80_0000, 32'hC000_0000, 1'b1);
      run_pair("fmax_pn",   1'b1, 32'h4000_0000, 32'hC000_0000, 32'h4000_0000, 1'b0);
   endtask

   task automatic test_ties();
      run_pair("fmin_zero", 1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
      run_pair("fmax_zero", 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
      run_pair("fmin_eq",   1'b0, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 1'b0);
      run_pair("fmax_eq",   1'b1, 32'hC040_0000, 32'hC040_0000, 32'hC040_0000, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] bx1 [4] = '{32'h3F80_0000, 32'hC000_0000, 32'h8000_0000, 32'h4120_0000};
      logic [31:0] bx2 [4] = '{32'h4000_0000, 32'hBF80_0000, 32'h0000_0000, 32'hC120_0000};
      logic        bop [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int acc = 0, got = 0, first = -1, last = -1;
      out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1; op = bop[acc]; x1 = bx1[acc]; x2 = bx2[acc];
         #1;
         if (c >= 2) begin
            nvec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== ref_y(bop[0], bx1[0], bx2[0])) begin
               nerr++;
               $display("FAIL stall_hold: in_ready=%b out_valid=%b y=%h, want 0 1 %h",
                        in_ready, out_valid, y, ref_y(bop[0], bx1[0], bx2[0]));
            end
         end
         if (in_ready) acc++;
         step();
      end
      nvec++;
      if (acc != 2) begin
         nerr++;
         $display("FAIL stall_accepts: accepted=%0d, want 2", acc);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = (acc < 4);
         if (acc < 4) begin op = bop[acc]; x1 = bx1[acc]; x2 = bx2[acc]; end
         #1;
         if (in_valid && in_ready) acc++;
         if (out_valid) begin
            nvec++;
            if (got >= 4) begin
               nerr++;
               $display("FAIL drain_dup: extra result y=%h", y);
            end else if (y !== ref_y(bop[got], bx1[got], bx2[got]) ||
                         lt !== ref_lt(bx1[got], bx2[got])) begin
               nerr++;
               $display("FAIL drain_%0d: y=%h lt=%b, want y=%h lt=%b", got, y, lt,
                        ref_y(bop[got], bx1[got], bx2[got]), ref_lt(bx1[got], bx2[got]));
            end
            if (first < 0) first = c;
            last = c;
            got++;
         end
         step();
      end
      in_valid = 1'b0;
      nvec++;
      if (got != 4 || last - first != 3) begin
         nerr++;
         $display("FAIL drain_count: got=%0d span=%0d, want 4 and 3", got, last - first);
      end
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      in_valid = 1'b1; op = 1'b0; x1 = 32'h3F80_0000; x2 = 32'h4000_0000;
      step();
      x1 = 32'h4000_0000; x2 = 32'h3F80_0000;
      step();
      in_valid = 1'b0;
      nvec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         nerr++;
         $display("FAIL full_before_rst: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
      end
      #2 rst = 1'b1;
      #1;
      nvec++;
      if (out_valid !== 1'b0 || y !== 32'h0 || lt !== 1'b0) begin
         nerr++;
         $display("FAIL async_rst: out_valid=%b y=%h lt=%b, want 0/0/0", out_valid, y, lt);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         nvec++;
         if (out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL stale_after_rst: out_valid=%b y=%h, want 0", out_valid, y);
         end
      end
      run_pair("post_rst", 1'b1, 32'hC080_0000, 32'h4080_0000, 32'h4080_0000, 1'b1);
   endtask

   task automatic test_random();
      localparam int N = 10000;
      logic [32:0] expq[$];
      logic [32:0] e;
      logic [31:0] py;
      logic        plt;
      bit          stall_prev = 0;
      int sent = 0, got = 0, cyc = 0;
      while (got < N && cyc < 60000) begin
         in_valid  = (sent < N) && ($urandom_range(0, 3) != 0);
         op        = 1'($urandom_range(0, 1));
         x1        = rnd_fp();
         x2        = ($urandom_range(0, 9) == 0) ? x1 : rnd_fp();
         out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (stall_prev) begin
            nvec++;
            if (out_valid !== 1'b1 || y !== py || lt !== plt) begin
               nerr++;
               $display("FAIL rnd_hold: out_valid=%b y=%h lt=%b, want 1 y=%h lt=%b",
                        out_valid, y, lt, py, plt);
            end
         end
         if (in_valid && in_ready) begin
            expq.push_back({ref_lt(x1, x2), ref_y(op, x1, x2)});
            sent++;
         end
         if (out_valid && out_ready) begin
            nvec++;
            if (expq.size() == 0) begin
               nerr++;
               $display("FAIL rnd_spurious: y=%h with nothing outstanding", y);
            end else begin
               e = expq.pop_front();
               if ({lt, y} !== e) begin
                  nerr++;
                  $display("FAIL rnd_result_%0d: y=%h lt=%b, want y=%h lt=%b",
                           got, y, lt, e[31:0], e[32]);
               end
            end
            got++;
         end
         stall_prev = out_valid && !out_ready;
         py  = y;
         plt = lt;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      nvec++;
      if (got != N) begin
         nerr++;
         $display("FAIL rnd_timeout: got=%0d results, want %0d", got, N);
      end
   endtask

   initial begin
      test_reset();
      test_ordering();
      test_ties();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
